// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, the receive-side partner of uart_tx.
//
// Recovers bytes (LSB first) from an asynchronous idle-high serial line
// using a single mid-bit sample per bit, and presents each byte through a
// valid/ack holding register.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   ack        consumer accepts data; only has an effect while valid=1
//   data[7:0]  received byte, stable while valid=1
//   valid      byte available, held until acknowledged
//   busy       high while a frame is in progress
//   frame_err  one-cycle pulse: stop bit was sampled low
//   overrun    one-cycle pulse: a good byte arrived while data was still held
module uart_rx #(
  parameter int CLK_HZ  = 12000000,
  parameter int BAUD    = 115200,
  parameter int DIVISOR = CLK_HZ / BAUD,
  parameter int HALF    = DIVISOR / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  // The cycle counter only ever counts up to DIVISOR-1 and is cleared at each
  // sample point, so clog2(DIVISOR) bits suffice even for power-of-two
  // divisors.
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic rx_meta;
  logic rx_s;
  logic rx_s_d;
  logic start_edge;

  // Two-flop synchronizer on the raw line plus one extra flop holding the
  // previous synchronized sample. They reset to 1 (idle line) so that leaving
  // reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // A frame starts only on a genuine high-to-low transition; a line that is
  // simply sitting low (e.g. a break) never retriggers the receiver.
  assign start_edge = !rx_s && rx_s_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic. The counter is cleared when leaving IDLE and at every
  // sample point: START samples after HALF cycles (middle of the start bit),
  // DATA and STOP after a further DIVISOR cycles each (middle of each bit).
  // The stop-bit sample cycle also decides the hand-off: a new byte may land
  // in the holding register if it is empty or is being acknowledged in that
  // same cycle, otherwise it is dropped and overrun pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == LAST_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            if (!valid_q || ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at default parameters.
//
// Frames are driven on rx either cycle-aligned (exact 115200 timing) or with
// real-valued bit periods for baud-skew cases. Expected hand-offs, framing
// errors and overruns are pushed to a scoreboard queue as frames are sent,
// and a negedge monitor pops and compares them as the DUT reports them.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CLK_HZ  = 12000000;
  localparam int  BAUD    = 115200;
  localparam int  DIV     = CLK_HZ / BAUD;
  localparam int  HALF    = DIV / 2;
  localparam int  LATENCY = 2 + HALF + 9 * DIV + 1;
  localparam real CLK_NS  = 10.0;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  typedef enum logic [1:0] {
    EV_HANDOFF,
    EV_FERR,
    EV_OVR
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] value;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_obs[$];
  ev_t  mon_exp;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  bit   mon_en       = 1'b0;
  logic valid_prev   = 1'b0;
  logic ack_edge     = 1'b0;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .ack      (ack),
    .data     (data),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #(CLK_NS / 2.0) clk = ~clk;
  end

  // Remember whether an ack was consumed at each edge, so the monitor can
  // tell a fresh hand-off into an acknowledged register from a held byte.
  always @(posedge clk) begin
    ack_edge <= (ack === 1'b1) && (valid === 1'b1);
  end

  // Scoreboard monitor: turn DUT outputs into events and compare each one
  // against the front of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_obs.delete();
      if (valid === 1'b1 && (valid_prev !== 1'b1 || ack_edge === 1'b1))
        mon_obs.push_back('{EV_HANDOFF, data});
      if (frame_err === 1'b1)
        mon_obs.push_back('{EV_FERR, 8'h00});
      if (overrun === 1'b1)
        mon_obs.push_back('{EV_OVR, 8'h00});
      foreach (mon_obs[k]) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL scoreboard_unexpected: got event kind=%0d data=%02h at %0t, required no event",
                   mon_obs[k].kind, mon_obs[k].value, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs[k] !== mon_exp) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_event: got kind=%0d data=%02h, required kind=%0d data=%02h at %0t",
                     mon_obs[k].kind, mon_obs[k].value, mon_exp.kind, mon_exp.value, $time);
          end
        end
      end
    end
    valid_prev <= valid;
  end

  // Drive one cycle-aligned frame; caller must be at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  // Drive one frame with an arbitrary real bit period, then realign.
  task automatic send_frame_skew(input logic [7:0] b, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = 1'b1;
    #(bit_ns);
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_queue_drained(input string name);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_missing_events: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    ack   = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    n_compared++;
    if (data !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %02h, required 00", data);
    end
    n_compared++;
    if ({valid, busy, frame_err, overrun} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got valid/busy/ferr/ovr=%b, required 0000",
               {valid, busy, frame_err, overrun});
    end
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int  lat;
    bit  got_valid;
    lat       = 0;
    got_valid = 1'b0;
    exp_q.push_back('{EV_HANDOFF, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 0; k < 2000 && !got_valid; k++) begin
          @(posedge clk);
          #1;
          lat = k + 1;
          if (valid === 1'b1) got_valid = 1'b1;
        end
      end
    join
    n_compared++;
    if (!got_valid || lat != LATENCY) begin
      n_mismatched++;
      $display("[TB] FAIL good_latency: got %0d cycles (seen=%0d), required %0d", lat, got_valid, LATENCY);
    end
    n_compared++;
    if (data !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL good_data: got %02h, required a5", data);
    end
    pulse_ack();
    n_compared++;
    if (valid !== 1'b0 || data !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL good_ack: got valid=%b data=%02h, required valid=0 data=a5", valid, data);
    end
    test_queue_drained("good");
  endtask

  task automatic test_glitch();
    int busy_cnt;
    busy_cnt = 0;
    pulse_ack();
    n_compared++;
    if (valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ack_while_empty: got valid=%b, required 0", valid);
    end
    rx = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (k == 19) rx = 1'b1;
    end
    n_compared++;
    if (busy_cnt != HALF) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_busy: got %0d busy cycles, required %0d", busy_cnt, HALF);
    end
    n_compared++;
    if (valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_valid: got %b, required 0", valid);
    end
    test_queue_drained("glitch");
  endtask

  task automatic test_frame_error();
    int busy_cnt;
    busy_cnt = 0;
    exp_q.push_back('{EV_FERR, 8'h00});
    send_frame(8'h3C, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    n_compared++;
    if (busy_cnt != 0 || valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL break_idle: got busy_cycles=%0d valid=%b, required 0 and 0", busy_cnt, valid);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back('{EV_HANDOFF, 8'h55});
    send_frame(8'h55, 1'b1);
    n_compared++;
    if (valid !== 1'b1 || data !== 8'h55) begin
      n_mismatched++;
      $display("[TB] FAIL after_break: got valid=%b data=%02h, required valid=1 data=55", valid, data);
    end
    pulse_ack();
    test_queue_drained("frame_error");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{EV_HANDOFF, 8'h01});
    exp_q.push_back('{EV_OVR, 8'h00});
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    n_compared++;
    if (valid !== 1'b1 || data !== 8'h01) begin
      n_mismatched++;
      $display("[TB] FAIL overrun_keep: got valid=%b data=%02h, required valid=1 data=01", valid, data);
    end
    pulse_ack();
    test_queue_drained("overrun");

    exp_q.push_back('{EV_HANDOFF, 8'h01});
    send_frame(8'h01, 1'b1);
    exp_q.push_back('{EV_HANDOFF, 8'h02});
    fork
      send_frame(8'h02, 1'b1);
      begin
        repeat (LATENCY - 1) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    n_compared++;
    if (valid !== 1'b1 || data !== 8'h02) begin
      n_mismatched++;
      $display("[TB] FAIL ack_on_handoff: got valid=%b data=%02h, required valid=1 data=02", valid, data);
    end
    pulse_ack();
    test_queue_drained("ack_on_handoff");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b  = 8'hC3;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = b[4];
    repeat (DIV / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    n_compared++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_state: got busy=%b valid=%b, required 0 and 0", busy, valid);
    end
    n_compared++;
    if (data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_outputs: got data=%02h ferr=%b ovr=%b, required 00/0/0",
               data, frame_err, overrun);
    end
    repeat (20) @(negedge clk);
    exp_q.push_back('{EV_HANDOFF, 8'hFF});
    send_frame(8'hFF, 1'b1);
    n_compared++;
    if (valid !== 1'b1 || data !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_next: got valid=%b data=%02h, required valid=1 data=ff", valid, data);
    end
    pulse_ack();
    test_queue_drained("reset_mid_frame");
  endtask

  task automatic test_baud_skew();
    real rates[2];
    rates[0] = 117500.0;
    rates[1] = 112900.0;
    foreach (rates[r]) begin
      exp_q.push_back('{EV_HANDOFF, 8'h96});
      send_frame_skew(8'h96, CLK_NS * CLK_HZ / rates[r]);
      repeat (30) @(negedge clk);
      n_compared++;
      if (valid !== 1'b1 || data !== 8'h96) begin
        n_mismatched++;
        $display("[TB] FAIL skew_%0d: got valid=%b data=%02h, required valid=1 data=96",
                 int'(rates[r]), valid, data);
      end
      pulse_ack();
      test_queue_drained("baud_skew");
    end
  endtask

  // Test sequence.
  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ack   = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_skew();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Samples an asynchronous serial line on the SB_HFOSC-derived system clock (12 MHz default) and recovers bytes, LSB first.
- Presents each byte through a valid/ack holding register.
- Flags bad stop bits and overruns, so host or debug traffic can reach FPGA logic alongside the ADC/DAC datapath.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIVISOR, CLK_HZ/BAUD (integer, truncating; 104 at defaults), clock cycles per bit. Must be >= 4.
- HALF, DIVISOR/2 (truncating; 52 at defaults), cycles from start edge to mid-start sample.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- ack  input  1  consumer accepts data; effective only while valid=1.
- data  output  8  received byte, stable while valid=1.
- valid  output  1  byte available; held until acknowledged.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: byte completed while the holding register was still full.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, bit/cycle counters=0, shift register=0, data=8'h00, valid=0, busy=0, frame_err=0, overrun=0. The two synchronizer flops and the previous-sample flop reset to 1. Reset mid-frame abandons the frame with no output, and the next cycle matches post-reset state.
- Input path: rx passes through a 2-flop synchronizer, giving rx_s (2 cycles latency). A third flop holds rx_s_d (previous rx_s).
- States: IDLE, START, DATA, STOP.
- Timing reference: let T be the cycle in IDLE where rx_s=0 and rx_s_d=1 (falling edge). A level-low line without an edge never starts a frame.
- START: sample rx_s at T+HALF.
  - rx_s=1: false start. Return to IDLE; no output, no flag.
  - rx_s=0: go to DATA.
- DATA: bit i (i=0..7) sampled at T+HALF+(i+1)*DIVISOR and shifted in LSB first.
- STOP: sampled at T+HALF+9*DIVISOR, then return to IDLE.
  - rx_s=1 (good frame): on the next cycle, hand off as follows.
    - Holding register empty (valid=0), or ack=1 in that same cycle: data<=byte, valid=1.
    - Holding register full (valid=1, ack=0): new byte dropped, data unchanged, overrun=1 for that one cycle.
  - rx_s=0: frame_err=1 for the next cycle. Byte discarded, valid unchanged. A held-low (break) line starts no new frame until it returns high and falls again.
- Latency: valid rises at T+HALF+9*DIVISOR+1, i.e. 2+HALF+9*DIVISOR+1 cycles after the rx pin falls (991 at defaults).
- Handshake:
  - ack=1 with valid=1 clears valid on the next cycle.
  - ack while valid=0 is ignored.
  - ack in the same cycle as a good-stop hand-off: valid stays 1, data takes the new byte, no overrun.
- busy: 1 from T+1 through the stop-sample cycle inclusive; 0 otherwise.
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample. A start edge arriving while in STOP is detected on the first IDLE cycle only if rx_s_d=1 there. Mid-stop sampling guarantees this for conforming frames.
- No parity. Only the single mid-bit sample is used, no majority vote. Tolerates about ±4% baud mismatch at the defaults.
- Counter widths: cycle counter is clog2(DIVISOR) bits, no wrap within a bit. Bit counter is 3 bits.

Test Plan:
- Good frame: send 0xA5 (defaults, exact 115200 timing) -> valid rises 991 cycles after the rx falling edge, data=0xA5, frame_err=0. Pulse ack for 1 cycle -> valid=0 on the next cycle, data remains 0xA5.
- Glitch: rx low for 20 cycles, then high -> busy high for 52 cycles then 0, no valid, no frame_err.
- Framing error and break:
  - Send 0x3C with stop bit 0 -> frame_err pulses exactly 1 cycle, valid stays 0.
  - Hold rx low a further 2000 cycles -> no new frame.
  - Release rx, then send 0x55 -> data=0x55, valid=1.
- Overrun: send 0x01 then 0x02 back-to-back without ack -> data=0x01 retained, overrun pulses 1 cycle at the second hand-off.
  - Repeat with ack asserted exactly on the second hand-off cycle -> data=0x02, valid=1, overrun=0.
- Reset mid-frame: assert reset for 1 cycle during bit 4 of 0xC3 -> next cycle busy=0, valid=0, data=0x00, no flags. A following 0xFF frame is received correctly.
- Baud skew: send 0x96 at 117500 bit/s (+2%) and at 112900 bit/s (-2%) -> data=0x96 both times, frame_err=0.
